// File: rtl/repetition_range.sv
// -----------------------------------------------------------------------------
// repetition_range
//
// Streaming regex primitive. Watches one character stream for a fixed byte
// pattern repeated between MIN_REP and MAX_REP times (inclusive) and reports
// each qualifying run with its start index, end index and repetition count.
// Runs never overlap; matching is leftmost-first and greedy up to MAX_REP.
//
// Parameters
//   PAT_LEN  pattern length in bytes (>= 1)
//   MIN_REP  minimum repetitions for a report (>= 1)
//   MAX_REP  maximum repetitions; reaching it forces a report (>= MIN_REP)
//   POS_W    width of the character counter and position outputs
//
// Ports
//   clk       in   sole clock, rising edge
//   reset     in   asynchronous, active-low reset
//   pattern   in   pattern bytes, byte 0 in [7:0]; stable while rdy=1
//   nextChar  in   input character
//   valid     in   nextChar is presented
//   done      in   end-of-stream pulse
//   rdy       out  block accepts valid/done
//   match     out  one-cycle pulse when a run is reported
//   startPos  out  index of the first char of the reported run
//   endPos    out  index of the last char of the last complete repetition
//   repCount  out  repetitions in the reported run
//
// Build option
//   REPETITION_CASE_FOLD_EN  when defined, ASCII A-Z are folded to a-z on both
//                            nextChar and pattern before comparison.
// -----------------------------------------------------------------------------
module repetition_range #(
   parameter int PAT_LEN = 2,
   parameter int MIN_REP = 1,
   parameter int MAX_REP = 4,
   parameter int POS_W   = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic [8*PAT_LEN-1:0]             pattern,
   input  logic [7:0]                       nextChar,
   input  logic                             valid,
   input  logic                             done,
   output logic                             rdy,
   output logic                             match,
   output logic [POS_W-1:0]                 startPos,
   output logic [POS_W-1:0]                 endPos,
   output logic [$clog2(MAX_REP+1)-1:0]     repCount
);

   localparam int REP_W  = $clog2(MAX_REP + 1);
   localparam int POS_IW = (PAT_LEN > 1) ? $clog2(PAT_LEN) : 1;

   localparam logic [POS_IW-1:0] LAST_POS = POS_IW'(PAT_LEN - 1);
   localparam logic [REP_W-1:0]  MIN_R    = REP_W'(MIN_REP);
   localparam logic [REP_W-1:0]  MAX_R    = REP_W'(MAX_REP);

   typedef enum logic {
      RUN,
      FLUSHED
   } state_t;

   // Optional ASCII case folding applied identically to both operands.
   function automatic logic [7:0] fold(input logic [7:0] c);
`ifdef REPETITION_CASE_FOLD_EN
      if (c >= 8'h41 && c <= 8'h5A) fold = c | 8'h20;
      else                          fold = c;
`else
      fold = c;
`endif
   endfunction

   // Registered state
   state_t              state_q, state_d;
   logic                rdy_q;
   logic [POS_W-1:0]    cnt_q, cnt_d;
   logic [POS_IW-1:0]   pos_q, pos_d;
   logic [REP_W-1:0]    rep_q, rep_d;
   logic [POS_W-1:0]    candStart_q, candStart_d;
   logic [POS_W-1:0]    candEnd_q, candEnd_d;
   logic                match_q;
   logic [POS_W-1:0]    startPos_q;
   logic [POS_W-1:0]    endPos_q;
   logic [REP_W-1:0]    repCount_q;

   // Report request for this cycle
   logic                rpt;
   logic [POS_W-1:0]    rptStart, rptEnd;
   logic [REP_W-1:0]    rptRep;

   logic [7:0]          patCur;
   logic [REP_W-1:0]    repInc;
   logic                eqCur, eqFirst;

   // Pattern byte currently expected
   always_comb begin
      patCur = pattern[7:0];
      for (int unsigned k = 0; k < PAT_LEN; k++) begin
         if (pos_q == POS_IW'(k)) patCur = pattern[8*k +: 8];
      end
   end

   assign eqCur   = (fold(nextChar) == fold(patCur));
   assign eqFirst = (fold(nextChar) == fold(pattern[7:0]));
   assign repInc  = rep_q + REP_W'(1);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      pos_d       = pos_q;
      rep_d       = rep_q;
      candStart_d = candStart_q;
      candEnd_d   = candEnd_q;
      rpt         = 1'b0;
      rptStart    = candStart_q;
      rptEnd      = candEnd_q;
      rptRep      = rep_q;

      if (state_q == RUN && rdy_q) begin
         if (valid) begin
            cnt_d = cnt_q + POS_W'(1);
            if (eqCur) begin
               if (pos_q == '0 && rep_q == '0) candStart_d = cnt_q;
               if (pos_q == LAST_POS) begin
                  pos_d     = '0;
                  candEnd_d = cnt_q;
                  if (repInc == MAX_R) begin
                     // Saturated run: report with the (possibly just-set) start.
                     rpt      = 1'b1;
                     rptStart = candStart_d;
                     rptEnd   = cnt_q;
                     rptRep   = MAX_R;
                     rep_d    = '0;
                  end else begin
                     rep_d = repInc;
                  end
               end else begin
                  pos_d = pos_q + POS_IW'(1);
               end
            end else begin
               // Report the run built so far; the partial tail is dropped.
               if (rep_q >= MIN_R) begin
                  rpt      = 1'b1;
                  rptStart = candStart_q;
                  rptEnd   = candEnd_q;
                  rptRep   = rep_q;
               end
               rep_d = '0;
               pos_d = '0;
               // Restart on pattern[0] only. With PAT_LEN==1 pos is always 0,
               // so a mismatch already failed against pattern[0].
               if (PAT_LEN > 1 && eqFirst) begin
                  candStart_d = cnt_q;
                  pos_d       = POS_IW'(1);
               end
            end
         end

         // A coincident char has already been folded into the *_d values.
         // Any report raised by that char left rep_d at 0, so at most one
         // report fires per cycle.
         if (done) begin
            if (rep_d >= MIN_R) begin
               rpt      = 1'b1;
               rptStart = candStart_d;
               rptEnd   = candEnd_d;
               rptRep   = rep_d;
            end
            state_d = FLUSHED;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= RUN;
         rdy_q       <= 1'b0;
         cnt_q       <= '0;
         pos_q       <= '0;
         rep_q       <= '0;
         candStart_q <= '0;
         candEnd_q   <= '0;
         match_q     <= 1'b0;
         startPos_q  <= '1;
         endPos_q    <= '1;
         repCount_q  <= '0;
      end else begin
         state_q     <= state_d;
         rdy_q       <= (state_d == RUN);
         cnt_q       <= cnt_d;
         pos_q       <= pos_d;
         rep_q       <= rep_d;
         candStart_q <= candStart_d;
         candEnd_q   <= candEnd_d;
         match_q     <= rpt;
         if (rpt) begin
            startPos_q <= rptStart;
            endPos_q   <= rptEnd;
            repCount_q <= rptRep;
         end
      end
   end

   assign rdy      = rdy_q;
   assign match    = match_q;
   assign startPos = startPos_q;
   assign endPos   = endPos_q;
   assign repCount = repCount_q;

endmodule

// File: tb/tb_repetition_range.sv
// -----------------------------------------------------------------------------
// tb_repetition_range
//
// Directed bench for repetition_range with pattern "ab", MIN_REP=2,
// MAX_REP=3, POS_W=32. Inputs change 1 time unit after the rising edge and
// outputs are sampled at the same point, so every registered response of the
// accepting edge is visible to the check that follows it.
// -----------------------------------------------------------------------------
module tb_repetition_range;

   logic        clk;
   logic        reset;
   logic [15:0] pattern;
   logic [7:0]  nextChar;
   logic        valid;
   logic        done;
   logic        rdy;
   logic        match;
   logic [31:0] startPos;
   logic [31:0] endPos;
   logic [1:0]  repCount;

   int checks = 0;
   int errors = 0;

   localparam logic [31:0] ONES = 32'hFFFF_FFFF;

   repetition_range #(
      .PAT_LEN (2),
      .MIN_REP (2),
      .MAX_REP (3),
      .POS_W   (32)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .pattern  (pattern),
      .nextChar (nextChar),
      .valid    (valid),
      .done     (done),
      .rdy      (rdy),
      .match    (match),
      .startPos (startPos),
      .endPos   (endPos),
      .repCount (repCount)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] c, input logic d);
      valid    = 1'b1;
      nextChar = c;
      done     = d;
      tick();
      valid    = 1'b0;
      done     = 1'b0;
   endtask

   task automatic send_done();
      done = 1'b1;
      tick();
      done = 1'b0;
   endtask

   // Feed a string one char per cycle; match must pulse only after index hit.
   task automatic send_str(input string s, input int hit, input string tag);
      for (int k = 0; k < s.len(); k++) begin
         send(s[k], 1'b0);
         check($sformatf("%s_match%0d", tag, k), 64'(match), 64'(k == hit));
         check($sformatf("%s_rdy%0d", tag, k), 64'(rdy), 64'd1);
      end
   endtask

   task automatic check_run(input string tag, input logic [31:0] s,
                            input logic [31:0] e, input logic [1:0] r);
      check({tag, "_start"}, 64'(startPos), 64'(s));
      check({tag, "_end"},   64'(endPos),   64'(e));
      check({tag, "_rep"},   64'(repCount), 64'(r));
   endtask

   // Hold reset for two edges, check reset values, then confirm rdy rises
   // on the first edge after release.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      tick();
      tick();
      check({tag, "_rst_rdy"},   64'(rdy),   64'd0);
      check({tag, "_rst_match"}, 64'(match), 64'd0);
      check_run({tag, "_rst"}, ONES, ONES, 2'd0);
      reset = 1'b1;
      check({tag, "_rel_rdy"}, 64'(rdy), 64'd0);
      tick();
      check({tag, "_up_rdy"}, 64'(rdy), 64'd1);
   endtask

   initial begin
      reset    = 1'b0;
      pattern  = {8'h62, 8'h61};   // "ab": byte 0 = 'a'
      nextChar = 8'h00;
      valid    = 1'b0;
      done     = 1'b0;
      #1;

      // Run ends on mismatch
      do_reset("s1");
      send_str("xababx", 5, "s1");
      check_run("s1", 32'd1, 32'd4, 2'd2);
      tick();
      check("s1_pulse_end", 64'(match), 64'd0);
      send_done();
      check("s1_done_match", 64'(match), 64'd0);
      check("s1_done_rdy",   64'(rdy),   64'd0);

      // Single repetition never qualifies
      do_reset("s2");
      send_str("abx", -1, "s2");
      send_done();
      check("s2_done_match", 64'(match), 64'd0);
      check_run("s2", ONES, ONES, 2'd0);

      // Saturation at MAX_REP, leftover single rep dropped at done
      do_reset("s3");
      send_str("abababab", 5, "s3");
      check_run("s3", 32'd0, 32'd5, 2'd3);
      send_done();
      check("s3_done_match", 64'(match), 64'd0);
      check_run("s3_hold", 32'd0, 32'd5, 2'd3);

      // Restart on pattern[0], report at done
      do_reset("s4");
      send_str("aabab", -1, "s4");
      send_done();
      check("s4_done_match", 64'(match), 64'd1);
      check_run("s4", 32'd1, 32'd4, 2'd2);
      tick();
      check("s4_after_rdy",   64'(rdy),   64'd0);
      check("s4_after_match", 64'(match), 64'd0);

      // Mid-stream reset discards state and restarts the index
      do_reset("s5a");
      send_str("aba", -1, "s5a");
      do_reset("s5b");
      send_str("abab", -1, "s5b");
      send_done();
      check("s5_done_match", 64'(match), 64'd1);
      check_run("s5", 32'd0, 32'd3, 2'd2);

      // Case folding; last char arrives together with done
      do_reset("s6");
      send_str("ABa", -1, "s6");
      send(8'h62, 1'b1);
`ifdef REPETITION_CASE_FOLD_EN
      check("s6_match", 64'(match), 64'd1);
      check_run("s6", 32'd0, 32'd3, 2'd2);
`else
      check("s6_match", 64'(match), 64'd0);
      check_run("s6", ONES, ONES, 2'd0);
`endif
      tick();
      check("s6_rdy", 64'(rdy), 64'd0);

      // Report and restart in the same cycle, second run reported at done
      do_reset("s7");
      send_str("ababaa", 5, "s7a");
      check_run("s7a", 32'd0, 32'd3, 2'd2);
      send_str("bab", -1, "s7b");
      send_done();
      check("s7_done_match", 64'(match), 64'd1);
      check_run("s7b", 32'd5, 32'd8, 2'd2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/repetition_range.md
# repetition_range

Streaming regex primitive that detects a fixed byte pattern repeated between MIN_REP and MAX_REP times, inclusive, in one character stream. It reports the start and end character index of each qualifying run, plus the repetition count. It sits in the regex datapath after the char-source front end and alongside the literal and pattern matchers. It adds a configurable pattern, a repetition bound, an input handshake, and restart-on-mismatch.

## Interface
- PAT_LEN, default 2: pattern length in bytes, ≥1.
- MIN_REP, default 1: minimum repetitions for a match, ≥1.
- MAX_REP, default 4: maximum repetitions, ≥MIN_REP. Reaching it forces a report.
- POS_W, default 32: width of the char counter and position outputs.
- clk  in  1  sole clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- pattern  in  8*PAT_LEN  pattern bytes; byte 0 is in bits [7:0]. Must be stable while rdy=1.
- nextChar  in  8  input character.
- valid  in  1  nextChar is presented.
- done  in  1  end of stream; one-cycle pulse.
- rdy  out  1  block accepts valid/done.
- match  out  1  one-cycle pulse when a qualifying run is reported.
- startPos  out  POS_W  index of the first char of the reported run.
- endPos  out  POS_W  index of the last char of the last complete repetition.
- repCount  out  $clog2(MAX_REP+1)  repetitions in the reported run.

## Operation
- States:
  - RUN: accepting characters.
  - FLUSHED: entered after done; rdy=0; left only by reset.
- Internal state:
  - charCounter: POS_W bits; +1 per accepted char; wraps modulo 2^POS_W.
  - pos: pattern index, 0..PAT_LEN-1.
  - rep: completed repetitions, 0..MAX_REP.
  - candStart, candEnd: start and end of the candidate run.
- Accepted char (valid && rdy), char c, index i:
  - c == pattern[pos]:
    - If pos==0 and rep==0: candStart=i.
    - If pos==PAT_LEN-1: rep+1, candEnd=i, pos=0. Otherwise pos+1.
    - If rep reaches MAX_REP: report, then rep=0.
  - Mismatch:
    - If rep≥MIN_REP: report (candStart, candEnd, rep). The partial tail is discarded.
    - Clear rep and pos.
    - Re-test c against pattern[0] in the same cycle. On equality: candStart=i, pos=1, or a completed repetition if PAT_LEN==1.
    - Only pattern[0] is re-tested; self-overlapping prefixes, e.g. "aab" in "aaab", are a known miss.
- done accepted (done && rdy):
  - If valid is also high, the char is processed first.
  - If rep≥MIN_REP after that: report.
  - Go to FLUSHED.
- Report: match=1 for one cycle. startPos/endPos/repCount are loaded and held until the next report.
- Runs never overlap; leftmost-first, greedy up to MAX_REP.

## Timing
- Reset values:
  - rdy=0, match=0.
  - startPos=endPos=all ones (-1), repCount=0.
  - charCounter=0, pos=0, rep=0, state RUN.
- rdy rises on the first clk edge after reset deasserts. It stays 1 in RUN and goes 0 the edge after done is accepted.
- Latency: match and its position outputs are registered, asserted the cycle after the accepting edge.
- Throughput: one char per cycle, with no stall in RUN.
- Simultaneous report and restart in one cycle: both happen. The report uses the pre-restart candidate.
- A MAX_REP report followed by a restart next cycle produces back-to-back match pulses.
- Reset mid-stream: all state is discarded and no pending report is emitted.
- Counter wrap: positions are reported modulo 2^POS_W; no flag.

## Configuration
- REPETITION_CASE_FOLD_EN:
  - Defined: compares nextChar and pattern bytes after folding ASCII A–Z to a–z. Non-letters are unchanged.
  - Undefined: exact 8-bit compare.
  - Positions and counts are identical in both builds.

## Test plan
All scenarios use pattern="ab", MIN_REP=2, MAX_REP=3, POS_W=32.
- "xababx": match pulse one cycle after index 5 is accepted; startPos=1, endPos=4, repCount=2.
- "abx" then done: no match; startPos/endPos remain all ones.
- "abababab" then done: match after index 5 with startPos=0, endPos=5, repCount=3. No second match on done (rep=1).
- "aabab" then done: restart on the second 'a'; match on done with startPos=1, endPos=4, repCount=2; rdy=0 afterwards.
- "aba", reset low for 2 cycles, then "abab" and done: outputs return to reset values; the post-reset run reports startPos=0, endPos=3, repCount=2.
- "ABab" then done:
  - With REPETITION_CASE_FOLD_EN: startPos=0, endPos=3, repCount=2.
  - Without it: no match.
